// File: rtl/accelerator_pkg.sv
// Shared accelerator types and OBI bus widths for the data-port arbiter slice.
package accelerator_pkg;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_VLSU = 1'b1
  } obi_owner_t;

  localparam int unsigned OBI_AW  = 32;
  localparam int unsigned OBI_DW  = 32;
  localparam int unsigned OBI_BEW = 4;

endpackage

// File: rtl/obi_owner_fifo.sv
// In-order FIFO recording which master issued each accepted OBI transaction.
module obi_owner_fifo
  import accelerator_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  obi_owner_t                     din,
  output obi_owner_t                     dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  obi_owner_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= OWNER_CORE;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vlsu_obi_arbiter.sv
// Two-master OBI data-port arbiter (core LSU m0, vector LSU m1) with in-order
// response routing, request locking across slave stalls, and sticky protocol error.
module vlsu_obi_arbiter
  import accelerator_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m0_req_i,
  output logic               m0_gnt_o,
  input  logic [OBI_AW-1:0]  m0_addr_i,
  input  logic               m0_we_i,
  input  logic [OBI_BEW-1:0] m0_be_i,
  input  logic [OBI_DW-1:0]  m0_wdata_i,
  output logic               m0_rvalid_o,
  output logic [OBI_DW-1:0]  m0_rdata_o,
  input  logic               m1_req_i,
  output logic               m1_gnt_o,
  input  logic [OBI_AW-1:0]  m1_addr_i,
  input  logic               m1_we_i,
  input  logic [OBI_BEW-1:0] m1_be_i,
  input  logic [OBI_DW-1:0]  m1_wdata_i,
  output logic               m1_rvalid_o,
  output logic [OBI_DW-1:0]  m1_rdata_o,
  output logic               data_req_o,
  input  logic               data_gnt_i,
  output logic [OBI_AW-1:0]  data_addr_o,
  output logic               data_we_o,
  output logic [OBI_BEW-1:0] data_be_o,
  output logic [OBI_DW-1:0]  data_wdata_o,
  input  logic               data_rvalid_i,
  input  logic [OBI_DW-1:0]  data_rdata_i,
  output logic               protocol_err_o
);

  obi_owner_t       sel;
  obi_owner_t       owner_q;
  obi_owner_t       last_q;
  obi_owner_t       head;
  logic             lock_q;
  logic             err_q;
  logic             sel_req;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  obi_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A locked owner keeps the bus so a stalled request stays stable.
  always_comb begin
    sel = OWNER_CORE;
    if (lock_q) begin
      sel = owner_q;
    end else if (m0_req_i && m1_req_i) begin
      sel = (last_q == OWNER_CORE) ? OWNER_VLSU : OWNER_CORE;
    end else if (m1_req_i) begin
      sel = OWNER_VLSU;
    end
  end

  assign sel_req    = (sel == OWNER_VLSU) ? m1_req_i : m0_req_i;
  assign data_req_o = sel_req && !fifo_full && !reset;
  assign push       = data_req_o && data_gnt_i;
  assign m0_gnt_o   = push && (sel == OWNER_CORE);
  assign m1_gnt_o   = push && (sel == OWNER_VLSU);

  always_comb begin
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;
    if (!reset) begin
      if (sel == OWNER_VLSU) begin
        data_addr_o  = m1_addr_i;
        data_we_o    = m1_we_i;
        data_be_o    = m1_be_i;
        data_wdata_o = m1_wdata_i;
      end else begin
        data_addr_o  = m0_addr_i;
        data_we_o    = m0_we_i;
        data_be_o    = m0_be_i;
        data_wdata_o = m0_wdata_i;
      end
    end
  end

  assign pop            = data_rvalid_i && !fifo_empty && !reset;
  assign m0_rvalid_o    = pop && (head == OWNER_CORE);
  assign m1_rvalid_o    = pop && (head == OWNER_VLSU);
  assign m0_rdata_o     = reset ? '0 : data_rdata_i;
  assign m1_rdata_o     = reset ? '0 : data_rdata_i;
  assign protocol_err_o = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q  <= 1'b0;
      owner_q <= OWNER_CORE;
      last_q  <= OWNER_VLSU;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        last_q <= sel;
      end
      // Dropping both requests while locked is illegal OBI, but unlocking avoids a deadlock.
      if (data_req_o && !data_gnt_i) begin
        lock_q  <= 1'b1;
        owner_q <= sel;
      end else if (lock_q && (data_gnt_i || (!m0_req_i && !m1_req_i))) begin
        lock_q <= 1'b0;
      end
      if (data_rvalid_i && (fifo_count == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vlsu_obi_arbiter.sv
// Directed, table-driven bench for vlsu_obi_arbiter with MAX_OUTSTANDING=2.
module tb_vlsu_obi_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [3:0]  m0_be_i;
  logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_be_i;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i, protocol_err_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vlsu_obi_arbiter #(
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_req_i       (m0_req_i),
    .m0_gnt_o       (m0_gnt_o),
    .m0_addr_i      (m0_addr_i),
    .m0_we_i        (m0_we_i),
    .m0_be_i        (m0_be_i),
    .m0_wdata_i     (m0_wdata_i),
    .m0_rvalid_o    (m0_rvalid_o),
    .m0_rdata_o     (m0_rdata_o),
    .m1_req_i       (m1_req_i),
    .m1_gnt_o       (m1_gnt_o),
    .m1_addr_i      (m1_addr_i),
    .m1_we_i        (m1_we_i),
    .m1_be_i        (m1_be_i),
    .m1_wdata_i     (m1_wdata_i),
    .m1_rvalid_o    (m1_rvalid_o),
    .m1_rdata_o     (m1_rdata_o),
    .data_req_o     (data_req_o),
    .data_gnt_i     (data_gnt_i),
    .data_addr_o    (data_addr_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_wdata_o   (data_wdata_o),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i),
    .protocol_err_o (protocol_err_o)
  );

  typedef struct {
    logic        m0r;
    logic [31:0] a0;
    logic        m1r;
    logic [31:0] a1;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        ereq;
    logic        esel;
    logic        eg0;
    logic        eg1;
    logic        erv0;
    logic        erv1;
    logic        eerr;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic m0r, input logic [31:0] a0, input logic m1r,
                              input logic [31:0] a1, input logic gnt, input logic rv,
                              input logic [31:0] rd, input logic ereq, input logic esel,
                              input logic eg0, input logic eg1, input logic erv0,
                              input logic erv1, input logic eerr);
    vec_t v;
    v.m0r = m0r; v.a0 = a0; v.m1r = m1r; v.a1 = a1; v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.ereq = ereq; v.esel = esel; v.eg0 = eg0; v.eg1 = eg1;
    v.erv0 = erv0; v.erv1 = erv1; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m0r, input logic [31:0] a0, input logic m1r,
                       input logic [31:0] a1, input logic gnt, input logic rv,
                       input logic [31:0] rd);
    m0_req_i      = m0r;
    m0_addr_i     = a0;
    m0_we_i       = 1'b1;
    m0_be_i       = 4'hF;
    m0_wdata_i    = a0 ^ 32'hA5A5_0000;
    m1_req_i      = m1r;
    m1_addr_i     = a1;
    m1_we_i       = 1'b0;
    m1_be_i       = 4'h3;
    m1_wdata_i    = a1 ^ 32'h5A5A_0000;
    data_gnt_i    = gnt;
    data_rvalid_i = rv;
    data_rdata_i  = rd;
  endtask

  function automatic logic [5:0] flags();
    return {data_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, protocol_err_o};
  endfunction

  initial begin
    // single m1 read, response two cycles later
    vecs[0]  = mk(0, 0,     1, 'h100, 1, 0, 0,            1, 1, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0,     0, 0,     1, 0, 0,            0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0,     0, 0,     0, 1, 'hDEADBEEF,   0, 0, 0, 0, 0, 1, 0);
    // tie round-robin with full stall and same-cycle push/pop at count 1
    vecs[3]  = mk(1, 'h10,  1, 'h20,  1, 0, 0,            1, 0, 1, 0, 0, 0, 0);
    vecs[4]  = mk(1, 'h10,  1, 'h20,  1, 0, 0,            1, 1, 0, 1, 0, 0, 0);
    vecs[5]  = mk(1, 'h10,  1, 'h20,  1, 1, 'h1111,       0, 0, 0, 0, 1, 0, 0);
    vecs[6]  = mk(1, 'h10,  1, 'h20,  1, 1, 'h2222,       1, 0, 1, 0, 0, 1, 0);
    vecs[7]  = mk(1, 'h10,  1, 'h20,  1, 1, 'h3333,       1, 1, 0, 1, 1, 0, 0);
    vecs[8]  = mk(0, 0,     0, 0,     0, 1, 'h4444,       0, 0, 0, 0, 0, 1, 0);
    // stall lock on m1 while m0 waits
    vecs[9]  = mk(0, 0,     1, 'h200, 0, 0, 0,            1, 1, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 'h300, 1, 'h200, 0, 0, 0,            1, 1, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 'h300, 1, 'h200, 0, 0, 0,            1, 1, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 'h300, 1, 'h200, 1, 0, 0,            1, 1, 0, 1, 0, 0, 0);
    vecs[13] = mk(1, 'h300, 1, 'h200, 1, 0, 0,            1, 0, 1, 0, 0, 0, 0);
    // full backpressure then reissue
    vecs[14] = mk(1, 'h300, 0, 0,     1, 0, 0,            0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(1, 'h300, 0, 0,     1, 1, 'h5555,       0, 0, 0, 0, 0, 1, 0);
    vecs[16] = mk(1, 'h300, 0, 0,     1, 0, 0,            1, 0, 1, 0, 0, 0, 0);
    vecs[17] = mk(0, 0,     0, 0,     0, 1, 'h6666,       0, 0, 0, 0, 1, 0, 0);
    vecs[18] = mk(0, 0,     0, 0,     0, 1, 'h7777,       0, 0, 0, 0, 1, 0, 0);
    // spurious rvalid sets the sticky error
    vecs[19] = mk(0, 0,     0, 0,     0, 1, 'h8888,       0, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 0,     0, 0,     0, 0, 0,            0, 0, 0, 0, 0, 0, 1);
    vecs[21] = mk(0, 0,     0, 0,     0, 0, 0,            0, 0, 0, 0, 0, 0, 1);
    // lock released when both masters drop req
    vecs[22] = mk(0, 0,     1, 'h240, 0, 0, 0,            1, 1, 0, 0, 0, 0, 1);
    vecs[23] = mk(0, 0,     0, 0,     0, 0, 0,            0, 0, 0, 0, 0, 0, 1);
    vecs[24] = mk(1, 'h300, 0, 0,     1, 0, 0,            1, 0, 1, 0, 0, 0, 1);
    vecs[25] = mk(0, 0,     0, 0,     0, 1, 'h9999,       0, 0, 0, 0, 1, 0, 1);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check("reset flags", 64'(flags()), 64'(6'b0));
    check("reset addr", 64'(data_addr_o), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      logic [31:0] ea;
      logic        ewe;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      @(negedge clk);
      drive(vecs[i].m0r, vecs[i].a0, vecs[i].m1r, vecs[i].a1, vecs[i].gnt, vecs[i].rv, vecs[i].rd);
      #1;
      check($sformatf("vec%0d flags", i), 64'(flags()),
            64'({vecs[i].ereq, vecs[i].eg0, vecs[i].eg1, vecs[i].erv0, vecs[i].erv1, vecs[i].eerr}));
      if (vecs[i].ereq) begin
        ea  = vecs[i].esel ? vecs[i].a1 : vecs[i].a0;
        ewe = vecs[i].esel ? 1'b0 : 1'b1;
        ebe = vecs[i].esel ? 4'h3 : 4'hF;
        ewd = vecs[i].esel ? (vecs[i].a1 ^ 32'h5A5A_0000) : (vecs[i].a0 ^ 32'hA5A5_0000);
        check($sformatf("vec%0d bus", i), {27'd0, data_addr_o, data_we_o, data_be_o}, {27'd0, ea, ewe, ebe});
        check($sformatf("vec%0d wdata", i), 64'(data_wdata_o), 64'(ewd));
      end
      if (vecs[i].rv) begin
        check($sformatf("vec%0d rdata", i), {m0_rdata_o, m1_rdata_o}, {vecs[i].rd, vecs[i].rd});
      end
    end

    // reset with a transaction outstanding: outputs forced low, response discarded
    @(negedge clk);
    drive(1, 'h500, 0, 0, 1, 0, 0);
    #1;
    check("pre-reset grant", 64'({data_req_o, m0_gnt_o}), 64'(2'b11));
    @(negedge clk);
    reset = 1'b1;
    drive(1, 'h500, 1, 'h600, 1, 0, 'h1234);
    #1;
    check("in-reset flags", 64'(flags()), 64'(6'b0));
    check("in-reset bus", {data_addr_o, data_wdata_o}, 64'(0));
    check("in-reset be/rdata", {27'd0, data_be_o, m0_rdata_o, data_we_o}, 64'(0));
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 'hAAAA);
    #1;
    check("post-reset rvalid", 64'(flags()), 64'(6'b0));
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("post-reset err", 64'(flags()), 64'(6'b000001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vlsu_obi_arbiter.md
Name: vlsu_obi_arbiter

Overview:
Two-master to one-slave OBI data-port arbiter placed directly downstream of the vector LSU's OBI master port. It merges vector LSU traffic (m1) with the core load/store unit (m0) onto the single data memory port. It tracks outstanding transactions in order and routes each response (rvalid/rdata) back to the master that issued it. It holds OBI request stability while the slave stalls.

Parameters:
MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions (1..8); depth of the owner FIFO
CNT_W, $clog2(MAX_OUTSTANDING+1), occupancy counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
m0_req_i  input  1  core LSU request
m0_gnt_o  output  1  grant to core LSU
m0_addr_i  input  32  core address
m0_we_i  input  1  core write enable
m0_be_i  input  4  core byte enables
m0_wdata_i  input  32  core write data
m0_rvalid_o  output  1  response valid to core
m0_rdata_o  output  32  read data to core
m1_req_i / m1_gnt_o / m1_addr_i / m1_we_i / m1_be_i / m1_wdata_i / m1_rvalid_o / m1_rdata_o  same widths  vector LSU side
data_req_o  output  1  memory request
data_gnt_i  input  1  memory grant
data_addr_o  output  32  memory address
data_we_o  output  1  memory write enable
data_be_o  output  4  memory byte enables
data_wdata_o  output  32  memory write data
data_rvalid_i  input  1  memory response valid (reads and writes)
data_rdata_i  input  32  memory read data
protocol_err_o  output  1  sticky: rvalid received with no outstanding transaction

Behaviour:
- Clock/reset: one clock `clk`; reset is asynchronous and active-high, named `reset`.
- Reset state: FIFO empty, count=0, lock_q=0, owner_q=M0, last_q=M1 (so m0 wins the first tie), protocol_err_o=0. All outputs 0 during reset (data_addr_o/wdata_o 0, be 0).
- Request path is combinational. No added cycles on req/addr/gnt; rvalid/rdata are combinational pass-through gated by the FIFO head.
- full = (count == MAX_OUTSTANDING).
- If full, data_req_o=0 and both gnt=0, even when data_rvalid_i pops in the same cycle. There is no rvalid->req comb path.
- Selection when unlocked and not full:
  - Only one master requests: select it.
  - Both request: select the master != last_q (round-robin).
- Lock:
  - If data_req_o && !data_gnt_i, set lock_q=1 and owner_q=selected master.
  - While locked, select owner_q regardless of the other master, so address, data, we and be stay stable per OBI.
  - Clear lock on data_gnt_i.
- Muxed outputs: data_req_o = selected master's req; addr/we/be/wdata muxed from the selected master.
- Grant: sel_gnt_o = data_gnt_i && data_req_o; the non-selected master's gnt=0.
- Accept (data_req_o && data_gnt_i): push selected owner ID (1 bit) into FIFO; last_q <= selected.
- Response: on data_rvalid_i with count>0, pop head.
  - m{head}_rvalid_o=1; other master's rvalid=0.
  - data_rdata_i is broadcast to both rdata ports.
- Simultaneous accept and response in one cycle: push and pop both occur, count unchanged, and ordering is preserved. When count==0 and both occur, the response belongs to an older transaction and is therefore an error (see next item).
- rvalid with count==0 (pop before push): ignored; no rvalid forwarded; protocol_err_o <= 1 until reset.
- A master dropping req while locked is illegal OBI. The arbiter does not check for it, but it must unlock if both reqs are 0 so it does not deadlock.
- Reset mid-transaction: outstanding responses are discarded; any rvalid after reset raises protocol_err_o.

Decomposition:
- Add to accelerator_pkg:
  - typedef enum logic {OWNER_CORE=1'b0, OWNER_VLSU=1'b1} obi_owner_t
  - localparam OBI_AW=32, OBI_DW=32, OBI_BEW=4
- Sub-module obi_owner_fifo: synchronous FIFO of obi_owner_t.
  - Params DEPTH.
  - Ports push/pop/din/dout/count/full/empty.
  - Same clock/reset. Simultaneous push+pop allowed at any occupancy except push when full.

Test Plan:
1. Single master: m1 reads addr 0x100, gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF -> m1_gnt_o=1 in cycle 0, m1_rvalid_o=1 with 0xDEADBEEF, m0_rvalid_o stays 0.
2. Tie and round-robin: both request every cycle, gnt always 1 -> grants alternate m0,m1,m0,m1; rvalids return in issue order, routed M0,M1,M0,M1.
3. Stall lock: m1 requests addr 0x200, data_gnt_i=0 for 3 cycles while m0 also requests -> data_addr_o held 0x200 and m0_gnt_o=0 all 3 cycles; grant to m1 on cycle 4, then m0 selected.
4. Full backpressure (MAX_OUTSTANDING=2): two accepted, no rvalid -> data_req_o=0 on the third request; after one rvalid, the next cycle reissues the request.
5. Same-cycle push/pop at count=1 -> count stays 1; next rvalid routed to the newly pushed owner.
6. Spurious rvalid at reset-idle -> no master rvalid; protocol_err_o=1 until reset asserted mid-stream, then 0.
